mastermind_scorer: RTL and testbench
====================================

Name: mastermind_scorer

Overview:
- Downstream of the secret-code and guess 4-bit peg registers.
- Consumes the flattened SECRET and GUESS words and computes the Mastermind score sequentially: BLACK counts exact colour+position matches, WHITE counts colour-only matches.
- Tracks the attempt count and raises WIN or LOSE, which drive the game controller and display.

Parameters:
- NUM_PEGS, 4, number of pegs per code.
- COLOR_W, 4, bits per peg (one 4-bit register per peg).
- MAX_TRIES, 10, attempts before LOSE; must be at most 2**TRY_W-1.
- TRY_W, 4, width of TRIES.
- SCORE_W, 3, width of BLACK/WHITE; must hold NUM_PEGS.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  synchronous reset, active-low.
- SECRET  input  NUM_PEGS*COLOR_W  secret code; peg k occupies bits [k*COLOR_W +: COLOR_W].
- GUESS  input  NUM_PEGS*COLOR_W  current guess, same packing.
- START  input  1  score request; sampled only in IDLE.
- NEW_GAME  input  1  clears game state; aborts any scoring in progress.
- BUSY  output  1  high while scoring.
- DONE  output  1  one-cycle pulse when BLACK/WHITE are valid.
- BLACK  output  SCORE_W  exact matches.
- WHITE  output  SCORE_W  colour-only matches.
- TRIES  output  TRY_W  scored attempts this game.
- WIN  output  1  sticky; set when BLACK==NUM_PEGS.
- LOSE  output  1  sticky; set when TRIES reaches MAX_TRIES without WIN.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low (RESET_N).
- Reset (RESET_N low at a rising CLK edge): state IDLE; all outputs 0; internal snapshots, flags and indices cleared. Reset overrides everything, including mid-scoring.
- States: IDLE, EXACT, COLOR, REPORT.
- IDLE:
  - START=1, NEW_GAME=0, WIN=0 and LOSE=0: snapshot SECRET/GUESS, clear BLACK/WHITE, clear flags sused[], gused[], set i=0, go to EXACT, BUSY=1.
  - START is ignored when WIN or LOSE is set.
- EXACT: one peg i per cycle, i=0..NUM_PEGS-1.
  - If g[i]==s[i]: BLACK++, gused[i]=1, sused[i]=1.
  - After i=NUM_PEGS-1, go to COLOR with i=j=0.
- COLOR: one (i,j) pair per cycle, j inner loop, NUM_PEGS*NUM_PEGS cycles.
  - If !gused[i] and !sused[j] and g[i]==s[j]: WHITE++, gused[i]=1, sused[j]=1.
  - After the last pair, go to REPORT.
- REPORT (one cycle):
  - DONE=1, BUSY=0, TRIES++.
  - WIN=1 if BLACK==NUM_PEGS.
  - Else LOSE=1 if the new TRIES==MAX_TRIES.
  - Then go to IDLE.
- Latency with defaults: START sampled at edge 0; DONE high in cycle 21 (4 EXACT + 16 COLOR + 1 REPORT).
- BLACK/WHITE hold their values in IDLE until the next accepted START. Changes on SECRET/GUESS during BUSY have no effect.
- Invariant: BLACK+WHITE <= NUM_PEGS. Duplicate colours are counted at most once per secret peg and once per guess peg.
- NEW_GAME=1 in any state: next state IDLE; TRIES, WIN, LOSE, BLACK, WHITE, BUSY, DONE all 0. NEW_GAME wins over a simultaneous START.
- START while BUSY is ignored (not queued).
- TRIES saturates at MAX_TRIES.

Optional Feature:
- Macro: MASTERMIND_SCORER_FAST_WIN_EN.
- Defined: if BLACK==NUM_PEGS at the end of EXACT, skip COLOR and go straight to REPORT. Default-parameter winning latency is DONE in cycle 5. All other guesses are unchanged at 21 cycles.
- Undefined: COLOR always runs; fixed 21-cycle latency for every guess.

Test Plan:
- Reset: drive RESET_N=0 for 2 cycles -> all outputs 0, state IDLE. Assert RESET_N=0 during COLOR -> BUSY=0, BLACK=WHITE=0, TRIES unchanged at 0 after the edge, no DONE.
- SECRET=16'h1234, GUESS=16'h1234, START -> DONE in cycle 21 (cycle 5 with MASTERMIND_SCORER_FAST_WIN_EN), BLACK=4, WHITE=0, TRIES=1, WIN=1. A following START is ignored.
- Case 3, SECRET=16'h1234, GUESS=16'h4321 -> BLACK=0, WHITE=4, WIN=0.
- Case 3, duplicate colours -> SECRET=16'h1123, GUESS=16'h1111 gives BLACK=2, WHITE=0; then SECRET=16'h1122, GUESS=16'h2211 gives BLACK=0, WHITE=4.
- Lose: 10 scored guesses of 16'h5555 against SECRET=16'h1234 -> each gives BLACK=0, WHITE=0; TRIES=10 and LOSE=1 at the 10th DONE; an 11th START gives no BUSY.
- NEW_GAME asserted mid-COLOR together with START -> IDLE next cycle, TRIES=0, WIN=LOSE=0, no DONE. A subsequent START scores normally.

Source files
------------

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact pass, then colour-only pairing pass, then one-cycle report.
// Latency 21 cycles from START (4 + 16 + 1). Define MASTERMIND_SCORER_FAST_WIN_EN to report a win after the exact pass.
// START is accepted only in IDLE with no WIN/LOSE; it is dropped while BUSY; NEW_GAME aborts any scoring.
module mastermind_scorer #(
    parameter int NUM_PEGS  = 4,
    parameter int COLOR_W   = 4,
    parameter int MAX_TRIES = 10,
    parameter int TRY_W     = 4,
    parameter int SCORE_W   = 3
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_PEGS*COLOR_W-1:0]   SECRET,
    input  logic [NUM_PEGS*COLOR_W-1:0]   GUESS,
    input  logic                          START,
    input  logic                          NEW_GAME,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [SCORE_W-1:0]            BLACK,
    output logic [SCORE_W-1:0]            WHITE,
    output logic [TRY_W-1:0]              TRIES,
    output logic                          WIN,
    output logic                          LOSE
);

    localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PEGS - 1);

    typedef enum logic [1:0] {IDLE, EXACT, COLOR, REPORT} state_t;

    state_t               state, state_nxt;
    logic [COLOR_W-1:0]   s_peg [NUM_PEGS];
    logic [COLOR_W-1:0]   g_peg [NUM_PEGS];
    logic [NUM_PEGS-1:0]  sused, gused;
    logic [IDX_W-1:0]     i, j;
    logic [SCORE_W-1:0]   black, white, black_fin;
    logic [TRY_W-1:0]     tries, tries_inc;
    logic                 win, lose;
    logic                 exact_hit, color_hit, start_ok, last_exact, last_pair;
    logic                 win_now, fast_win, enter_report;

    always_comb begin
        exact_hit  = (g_peg[i] == s_peg[i]);
        color_hit  = !gused[i] && !sused[j] && (g_peg[i] == s_peg[j]);
        start_ok   = START && !NEW_GAME && !win && !lose;
        last_exact = (i == LAST);
        last_pair  = last_exact && (j == LAST);
        // The final exact hit lands on the same edge that leaves EXACT, so fold it in here.
        black_fin  = (state == EXACT) ? black + SCORE_W'(exact_hit) : black;
        win_now    = (black_fin == SCORE_W'(NUM_PEGS));
        tries_inc  = (tries == TRY_W'(MAX_TRIES)) ? tries : tries + 1'b1;
`ifdef MASTERMIND_SCORER_FAST_WIN_EN
        fast_win   = win_now;
`else
        fast_win   = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = EXACT;
            EXACT:   if (last_exact) state_nxt = fast_win ? REPORT : COLOR;
            COLOR:   if (last_pair) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (NEW_GAME) state_nxt = IDLE;
    end

    always_comb begin
        BUSY = (state == EXACT) || (state == COLOR);
        DONE = (state == REPORT);
    end

    // Score/try flags are committed on entry to REPORT so everything is valid while DONE is high.
    assign enter_report = (state_nxt == REPORT);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_PEGS; k++) begin
                s_peg[k] <= '0;
                g_peg[k] <= '0;
            end
            sused <= '0;
            gused <= '0;
            i     <= '0;
            j     <= '0;
            black <= '0;
            white <= '0;
            tries <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else if (NEW_GAME) begin
            black <= '0;
            white <= '0;
            tries <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    for (int k = 0; k < NUM_PEGS; k++) begin
                        s_peg[k] <= SECRET[k*COLOR_W +: COLOR_W];
                        g_peg[k] <= GUESS[k*COLOR_W +: COLOR_W];
                    end
                    sused <= '0;
                    gused <= '0;
                    i     <= '0;
                    j     <= '0;
                    black <= '0;
                    white <= '0;
                end
                EXACT: begin
                    if (exact_hit) begin
                        black    <= black + 1'b1;
                        gused[i] <= 1'b1;
                        sused[i] <= 1'b1;
                    end
                    i <= last_exact ? '0 : i + 1'b1;
                    j <= '0;
                end
                COLOR: begin
                    if (color_hit) begin
                        white    <= white + 1'b1;
                        gused[i] <= 1'b1;
                        sused[j] <= 1'b1;
                    end
                    if (j == LAST) begin
                        j <= '0;
                        i <= last_exact ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
            if (enter_report) begin
                tries <= tries_inc;
                if (win_now)
                    win <= 1'b1;
                else if (tries_inc == TRY_W'(MAX_TRIES))
                    lose <= 1'b1;
            end
        end
    end

    assign BLACK = black;
    assign WHITE = white;
    assign TRIES = tries;
    assign WIN   = win;
    assign LOSE  = lose;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: vector table, hand-written corner sequences, and random guesses vs a counting model.
module tb_mastermind_scorer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] SECRET = '0;
    logic [15:0] GUESS = '0;
    logic        START = 1'b0;
    logic        NEW_GAME = 1'b0;
    logic        BUSY, DONE, WIN, LOSE;
    logic [2:0]  BLACK, WHITE;
    logic [3:0]  TRIES;

    int n_checks = 0;
    int n_fail = 0;

    mastermind_scorer dut (
        .CLK(CLK), .RESET_N(RESET_N), .SECRET(SECRET), .GUESS(GUESS),
        .START(START), .NEW_GAME(NEW_GAME), .BUSY(BUSY), .DONE(DONE),
        .BLACK(BLACK), .WHITE(WHITE), .TRIES(TRIES), .WIN(WIN), .LOSE(LOSE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] s;
        logic [15:0] g;
        int          b;
        int          w;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Black = positional matches; white = per-colour min of leftover counts.
    function automatic void model(input logic [15:0] s, input logic [15:0] g,
                                  output int b, output int w);
        int sc[16];
        int gc[16];
        logic [3:0] sp, gp;
        b = 0;
        w = 0;
        for (int c = 0; c < 16; c++) begin
            sc[c] = 0;
            gc[c] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            sp = s[k*4 +: 4];
            gp = g[k*4 +: 4];
            if (sp == gp) b++;
            else begin
                sc[sp]++;
                gc[gp]++;
            end
        end
        for (int c = 0; c < 16; c++) w += (sc[c] < gc[c]) ? sc[c] : gc[c];
    endfunction

    task automatic new_game();
        @(negedge CLK);
        NEW_GAME = 1'b1;
        @(negedge CLK);
        NEW_GAME = 1'b0;
    endtask

    task automatic score(input logic [15:0] s, input logic [15:0] g, input int eb, input int ew,
                         input int et, input int ewin, input int elose, input string nm);
        int cyc;
        int elat;
        @(negedge CLK);
        SECRET = s;
        GUESS  = g;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        SECRET = 16'($urandom);
        GUESS  = 16'($urandom);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) check({nm, " busy"}, int'(BUSY), 1);
        end while (!DONE && cyc < 40);
        elat = 21;
`ifdef MASTERMIND_SCORER_FAST_WIN_EN
        if (eb == 4) elat = 5;
`endif
        check({nm, " latency"}, cyc, elat);
        check({nm, " black"}, int'(BLACK), eb);
        check({nm, " white"}, int'(WHITE), ew);
        check({nm, " tries"}, int'(TRIES), et);
        check({nm, " win"}, int'(WIN), ewin);
        check({nm, " lose"}, int'(LOSE), elose);
        check({nm, " busy@done"}, int'(BUSY), 0);
        @(negedge CLK);
        check({nm, " done pulse"}, int'(DONE), 0);
        check({nm, " black hold"}, int'(BLACK), eb);
    endtask

    vec_t vecs[6];
    int   mb, mw, seen, et;
    int   ewin, elose;
    logic [15:0] rs, rg;

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 4, 0};
        vecs[1] = '{16'h1234, 16'h4321, 0, 4};
        vecs[2] = '{16'h1123, 16'h1111, 2, 0};
        vecs[3] = '{16'h1122, 16'h2211, 0, 4};
        vecs[4] = '{16'h1234, 16'h1243, 2, 2};
        vecs[5] = '{16'h0000, 16'hFFFF, 0, 0};

        // Reset held for two cycles.
        repeat (2) @(negedge CLK);
        check("reset busy", int'(BUSY), 0);
        check("reset done", int'(DONE), 0);
        check("reset black", int'(BLACK), 0);
        check("reset white", int'(WHITE), 0);
        check("reset tries", int'(TRIES), 0);
        check("reset win", int'(WIN), 0);
        check("reset lose", int'(LOSE), 0);
        RESET_N = 1'b1;

        foreach (vecs[v]) begin
            new_game();
            score(vecs[v].s, vecs[v].g, vecs[v].b, vecs[v].w, 1, (vecs[v].b == 4) ? 1 : 0, 0,
                  $sformatf("vec%0d", v));
        end

        // A win blocks further START.
        new_game();
        score(16'h1234, 16'h1234, 4, 0, 1, 1, 0, "win");
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("start after win busy", int'(BUSY), 0);
        check("start after win tries", int'(TRIES), 1);

        // Ten misses lose; the eleventh START is ignored.
        new_game();
        for (int t = 1; t <= 10; t++)
            score(16'h1234, 16'h5555, 0, 0, t, 0, (t == 10) ? 1 : 0, $sformatf("lose%0d", t));
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("start after lose busy", int'(BUSY), 0);
        check("start after lose tries", int'(TRIES), 10);

        // Reset during the colour pass.
        new_game();
        @(negedge CLK);
        SECRET = 16'h1234;
        GUESS  = 16'h4321;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre-reset busy", int'(BUSY), 1);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check("midreset busy", int'(BUSY), 0);
        check("midreset black", int'(BLACK), 0);
        check("midreset white", int'(WHITE), 0);
        check("midreset tries", int'(TRIES), 0);
        seen = 0;
        repeat (25) begin
            @(negedge CLK);
            if (DONE || BUSY) seen++;
        end
        check("midreset no done", seen, 0);

        // NEW_GAME with START during the colour pass.
        score(16'h1234, 16'h5555, 0, 0, 1, 0, 0, "pre-ng");
        @(negedge CLK);
        SECRET = 16'h1234;
        GUESS  = 16'h4321;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        NEW_GAME = 1'b1;
        START    = 1'b1;
        @(negedge CLK);
        NEW_GAME = 1'b0;
        START    = 1'b0;
        check("newgame busy", int'(BUSY), 0);
        check("newgame done", int'(DONE), 0);
        check("newgame tries", int'(TRIES), 0);
        check("newgame win", int'(WIN), 0);
        check("newgame lose", int'(LOSE), 0);
        check("newgame black", int'(BLACK), 0);
        seen = 0;
        repeat (25) begin
            @(negedge CLK);
            if (DONE || BUSY) seen++;
        end
        check("newgame no done", seen, 0);
        score(16'h1122, 16'h2211, 0, 4, 1, 0, 0, "after-ng");

        // Random games with a small colour set to force duplicates.
        new_game();
        et = 0;
        ewin = 0;
        elose = 0;
        for (int r = 0; r < 40; r++) begin
            if (ewin != 0 || elose != 0) begin
                new_game();
                et = 0;
                ewin = 0;
                elose = 0;
            end
            for (int k = 0; k < 4; k++) begin
                rs[k*4 +: 4] = 4'($urandom_range(0, 3));
                rg[k*4 +: 4] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 5) == 0) rg = rs;
            model(rs, rg, mb, mw);
            if (et < 10) et++;
            if (mb == 4) ewin = 1;
            else if (et == 10) elose = 1;
            score(rs, rg, mb, mw, et, ewin, elose, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
